// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Observes a single-cycle CPU's program counter and a set of probe channels.
// It decides when the running program has finished, then checks the probes
// against expected values and reports the result.
//
// A run ends on one of three events:
//   - halt PC:  the PC equals halt_pc;
//   - self-loop: the PC has not changed for STALL_CYC consecutive cycles;
//   - timeout:  MAX_CYC run cycles have elapsed without a halt.
// This replaces a fixed run delay.
//
// After the run ends, the monitor waits SETTLE_CYC cycles before it samples the
// probes. The monitor is purely observational and never drives the CPU.
//
// Optional feature macro: CPU_RUN_MONITOR_TRACE_EN
//   When this macro is defined, the monitor keeps a TRACE_DEPTH-entry circular
//   history of the PC. One entry is written on every RUN cycle. The history can
//   be read back combinationally through trace_idx/trace_pc, where index 0 is
//   the newest entry.
//   When the macro is undefined, no trace storage exists and trace_pc reads 0.
//
// Ports
//   clk          in   CPU clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   pulse; begins monitoring (accepted in IDLE or DONE only)
//   pc           in   CPU PC, sampled every cycle
//   halt_pc      in   address of the last instruction
//   chk_data     in   probe values; channel i = bits [i*DATA_W +: DATA_W]
//   chk_expect   in   expected values, same packing as chk_data
//   chk_enable   in   per-channel compare enable
//   busy         out  high while in RUN or SETTLE
//   done         out  high while in DONE
//   pass         out  done, no enabled mismatch and no timeout
//   timeout      out  the run was ended by MAX_CYC
//   mismatch     out  per-channel mismatch, latched at CHECK
//   cycle_count  out  RUN cycles up to and including the halting cycle
//   trace_idx    in   trace read index, 0 = newest
//   trace_pc     out  trace entry (combinational read)
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NCHK        = 2,
    parameter int CNT_W       = 16,
    parameter int STALL_CYC   = 3,
    parameter int SETTLE_CYC  = 2,
    parameter int MAX_CYC     = 1000,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                pc,
    input  logic [ADDR_W-1:0]                halt_pc,
    input  logic [NCHK*DATA_W-1:0]           chk_data,
    input  logic [NCHK*DATA_W-1:0]           chk_expect,
    input  logic [NCHK-1:0]                  chk_enable,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [NCHK-1:0]                  mismatch,
    output logic [CNT_W-1:0]                 cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_idx,
    output logic [ADDR_W-1:0]                trace_pc
);

    // The stall counter must be able to hold STALL_CYC itself.
    localparam int STALL_W         = $clog2(STALL_CYC + 1);
    localparam int SETTLE_LAST_I   = (SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0;

    localparam logic [CNT_W-1:0]   MAX_CYC_C     = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0]   SETTLE_LAST_C = CNT_W'(SETTLE_LAST_I);
    localparam logic [CNT_W-1:0]   CNT_ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ALL1_C    = {CNT_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_LAST_C  = STALL_W'(STALL_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_ONE_C   = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_ALL1_C  = {STALL_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Per-channel compare. A disabled channel never reports a mismatch.
    function automatic logic [NCHK-1:0] calc_mismatch(
        input logic [NCHK*DATA_W-1:0] data_v,
        input logic [NCHK*DATA_W-1:0] expect_v,
        input logic [NCHK-1:0]        enable_v
    );
        logic [NCHK-1:0] mm;
        mm = {NCHK{1'b0}};
        for (int i = 0; i < NCHK; i++) begin
            mm[i] = enable_v[i] &
                    (data_v[i*DATA_W +: DATA_W] != expect_v[i*DATA_W +: DATA_W]);
        end
        return mm;
    endfunction

    state_t               state_r;
    state_t               state_n_s;
    logic [CNT_W-1:0]     cycle_count_r;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [CNT_W-1:0]     settle_cnt_r;
    logic [STALL_W-1:0]   stall_cnt_r;
    logic [ADDR_W-1:0]    prev_pc_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic                 timeout_r;
    logic [NCHK-1:0]      mismatch_r;

    logic                 start_ok_s;
    logic                 pc_same_s;
    logic                 stall_hit_s;
    logic                 halt_s;
    logic                 tmo_s;
    logic                 run_end_s;
    logic [NCHK-1:0]      mm_s;

    // A start pulse only counts in IDLE or DONE.
    assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // The cycle counter saturates at all-ones rather than wrapping.
    assign cnt_inc_s   = (cycle_count_r == CNT_ALL1_C) ? cycle_count_r
                                                       : (cycle_count_r + CNT_ONE_C);

    // stall_cnt_r holds the number of equal-PC cycles already seen. The current
    // cycle completes the loop when it is equal and STALL_CYC-1 were seen before.
    assign pc_same_s   = (pc == prev_pc_r);
    assign stall_hit_s = pc_same_s & (stall_cnt_r >= STALL_LAST_C);
    assign halt_s      = (pc == halt_pc) | stall_hit_s;

    // If a halt and a timeout occur in the same cycle, the halt wins.
    assign tmo_s       = ~halt_s & (cnt_inc_s >= MAX_CYC_C);
    assign run_end_s   = halt_s | tmo_s;
    assign mm_s        = calc_mismatch(chk_data, chk_expect, chk_enable);

    // Next-state logic for the run/settle/check sequence.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_end_s) begin
                    state_n_s = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r >= SETTLE_LAST_C) begin
                    state_n_s = ST_CHECK;
                end else begin
                    state_n_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                state_n_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register, plus busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            busy_r  <= (state_n_s == ST_RUN) | (state_n_s == ST_SETTLE);
            done_r  <= (state_n_s == ST_DONE);
        end
    end

    // The previous-cycle PC is captured every cycle, regardless of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_r <= {ADDR_W{1'b0}};
        end else begin
            prev_pc_r <= pc;
        end
    end

    // Run-cycle, stall and settle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_r <= {CNT_W{1'b0}};
            stall_cnt_r   <= {STALL_W{1'b0}};
            settle_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cycle_count_r <= {CNT_W{1'b0}};
                        stall_cnt_r   <= {STALL_W{1'b0}};
                    end else begin
                        cycle_count_r <= cycle_count_r;
                        stall_cnt_r   <= stall_cnt_r;
                    end
                    settle_cnt_r <= {CNT_W{1'b0}};
                end
                ST_RUN: begin
                    // The halting cycle is included in the count; the counter freezes after it.
                    cycle_count_r <= cnt_inc_s;
                    if (pc_same_s) begin
                        stall_cnt_r <= (stall_cnt_r == STALL_ALL1_C) ? stall_cnt_r
                                                                     : (stall_cnt_r + STALL_ONE_C);
                    end else begin
                        stall_cnt_r <= {STALL_W{1'b0}};
                    end
                    settle_cnt_r <= {CNT_W{1'b0}};
                end
                ST_SETTLE: begin
                    settle_cnt_r <= settle_cnt_r + CNT_ONE_C;
                end
                ST_CHECK: begin
                    settle_cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cycle_count_r <= {CNT_W{1'b0}};
                    stall_cnt_r   <= {STALL_W{1'b0}};
                    settle_cnt_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Result registers: cleared by an accepted start, timeout set at the end of
    // RUN, and the probe verdict latched on leaving CHECK.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_r  <= 1'b0;
            mismatch_r <= {NCHK{1'b0}};
            pass_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        timeout_r  <= 1'b0;
                        mismatch_r <= {NCHK{1'b0}};
                        pass_r     <= 1'b0;
                    end else begin
                        timeout_r  <= timeout_r;
                        mismatch_r <= mismatch_r;
                        pass_r     <= pass_r;
                    end
                end
                ST_RUN: begin
                    timeout_r <= tmo_s;
                end
                ST_CHECK: begin
                    mismatch_r <= mm_s;
                    pass_r     <= ~timeout_r & (mm_s == {NCHK{1'b0}});
                end
                default: begin
                    timeout_r <= timeout_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign timeout     = timeout_r;
    assign mismatch    = mismatch_r;
    assign cycle_count = cycle_count_r;

`ifdef CPU_RUN_MONITOR_TRACE_EN
    localparam int TR_W = $clog2(TRACE_DEPTH);

    logic [ADDR_W-1:0] trace_mem_r [TRACE_DEPTH];
    logic [TR_W-1:0]   trace_wr_r;
    logic [TR_W-1:0]   trace_rd_s;

    // Circular PC history. It is written on every RUN cycle, frozen at all
    // other times, and cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem_r[i] <= {ADDR_W{1'b0}};
            end
            trace_wr_r <= {TR_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            trace_mem_r[trace_wr_r] <= pc;
            trace_wr_r              <= trace_wr_r + TR_W'(1);
        end else begin
            trace_wr_r <= trace_wr_r;
        end
    end

    // The newest entry sits one slot behind the write pointer. Slots that were
    // never written still hold the cleared value, so they read as 0.
    assign trace_rd_s = trace_wr_r - TR_W'(1) - trace_idx;
    assign trace_pc   = trace_mem_r[trace_rd_s];
`else
    logic unused_trace_idx;
    logic unused_start_ok;

    assign unused_trace_idx = ^trace_idx;
    assign unused_start_ok  = start_ok_s;
    assign trace_pc         = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor with the default parameters.
// The reference model walks the PC history of each run and finds the first
// halt, self-loop or timeout cycle. The probes are judged channel by channel.
module tb_cpu_run_monitor;

    localparam int          MAX_CYC    = 1000;
    localparam int          STALL_CYC  = 3;
    localparam int          SETTLE_CYC = 2;
    localparam logic [31:0] IDLE_PC    = 32'hDEAD_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] halt_pc;
    logic [63:0] chk_data;
    logic [63:0] chk_expect;
    logic [1:0]  chk_enable;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [1:0]  mismatch;
    logic [15:0] cycle_count;
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;

    int checks;
    int failures;
    logic [31:0] seq [$];

    cpu_run_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .halt_pc     (halt_pc),
        .chk_data    (chk_data),
        .chk_expect  (chk_expect),
        .chk_enable  (chk_enable),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .mismatch    (mismatch),
        .cycle_count (cycle_count),
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns the 1-based RUN cycle at which the run ends,
    // and whether that end is a timeout.
    function automatic void model_run(input logic [31:0] hpc, output int h, output logic tmo);
        logic [31:0] prev;
        logic [31:0] p;
        int same;
        prev = IDLE_PC;
        same = 0;
        h    = MAX_CYC;
        tmo  = 1'b1;
        for (int k = 1; k <= MAX_CYC; k++) begin
            p    = seq[k-1];
            same = (p == prev) ? same + 1 : 0;
            if (p == hpc || same >= STALL_CYC) begin
                h   = k;
                tmo = 1'b0;
                return;
            end
            if (k == MAX_CYC) begin
                return;
            end
            prev = p;
        end
    endfunction

    // Fills seq with MAX_CYC PCs. Modes: 0 = incrementing with halt_pc on the
    // path, 1 = increment then stick, 2 = random small PCs, 3 = never halts.
    task automatic gen(input int mode);
        logic [31:0] base;
        logic [31:0] p;
        int n;
        seq.delete();
        base = 32'($urandom_range(0, 255)) * 32'd4;
        case (mode)
            0: begin
                for (int i = 0; i < MAX_CYC; i++) seq.push_back(base + 32'(4 * i));
                halt_pc = seq[$urandom_range(0, 80)];
            end
            1: begin
                n = $urandom_range(1, 30);
                p = base;
                for (int i = 0; i < MAX_CYC; i++) begin
                    if (i < n) p = base + 32'(4 * i);
                    seq.push_back(p);
                end
                halt_pc = 32'hFFFF_FFFC;
            end
            2: begin
                for (int i = 0; i < MAX_CYC; i++) seq.push_back(32'($urandom_range(0, 3)) * 32'd4);
                halt_pc = 32'h8000_0000;
            end
            default: begin
                for (int i = 0; i < MAX_CYC; i++) seq.push_back(base + 32'(4 * i));
                halt_pc = 32'hFFFF_FFF0;
            end
        endcase
    endtask

    // Drives one complete run from seq, then checks every result against the model.
    task automatic do_run(input string nm, input int mid_start);
        int h;
        int n;
        logic tmo;
        logic [1:0] mm;
        logic [31:0] exp_tr;
        model_run(halt_pc, h, tmo);
        for (int c = 0; c < 2; c++) begin
            mm[c] = chk_enable[c] & (chk_data[32*c +: 32] != chk_expect[32*c +: 32]);
        end
        pc    = IDLE_PC;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_start_busy"}, 64'(busy), 64'd1);
        check({nm, "_start_clr"}, {46'd0, done, timeout, cycle_count}, 64'd0);
        for (int k = 0; k < h; k++) begin
            pc    = seq[k];
            start = (k == mid_start) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        check({nm, "_settle_busy"}, {62'd0, busy, done}, 64'h2);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check({nm, "_done_lat"}, 64'(n), 64'(SETTLE_CYC + 1));
        check({nm, "_done"}, {62'd0, done, busy}, 64'h2);
        check({nm, "_count"}, 64'(cycle_count), 64'(h));
        check({nm, "_timeout"}, 64'(timeout), 64'(tmo));
        check({nm, "_mismatch"}, 64'(mismatch), 64'(mm));
        check({nm, "_pass"}, 64'(pass), 64'(~tmo & (mm == 2'b00)));
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
`ifdef CPU_RUN_MONITOR_TRACE_EN
            exp_tr = (i < h) ? seq[h-1-i] : 32'd0;
`else
            exp_tr = 32'd0;
`endif
            check($sformatf("%s_trace%0d", nm, i), 64'(trace_pc), 64'(exp_tr));
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        pc         = IDLE_PC;
        halt_pc    = 32'd0;
        chk_data   = 64'd0;
        chk_expect = 64'd0;
        chk_enable = 2'b00;
        trace_idx  = 3'd0;
        tick();
        tick();
        check("rst_flags", {60'd0, busy, done, pass, timeout}, 64'd0);
        check("rst_mm_cnt", {46'd0, mismatch, cycle_count}, 64'd0);
        check("rst_trace", 64'(trace_pc), 64'd0);
        reset = 1'b0;
        tick();

        // Reset during the fifth RUN cycle, with start also high: reset must win.
        halt_pc = 32'hFFFF_FFF0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pc = 32'(4 * k);
            tick();
        end
        check("midrun_busy", 64'(busy), 64'd1);
        pc    = 32'd16;
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("midrst_out", {62'd0, busy, done}, 64'd0);
        check("midrst_cnt", 64'(cycle_count), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("midrst_idle", 64'(busy), 64'd0);

        // Halt PC 0x14 after the sequence 0,4,..,0x14; channel 0 matches.
        seq.delete();
        for (int i = 0; i < MAX_CYC; i++) seq.push_back(32'(4 * i));
        halt_pc    = 32'h14;
        chk_enable = 2'b01;
        chk_data   = {32'd99, 32'd48};
        chk_expect = {32'd1, 32'd48};
        do_run("haltpc", -1);

        // PC sticks at 0x20; channel 1 expects 5 but sees 7.
        seq.delete();
        for (int i = 0; i < MAX_CYC; i++) seq.push_back((i < 4) ? 32'h10 + 32'(4 * i) : 32'h20);
        halt_pc    = 32'hFFC;
        chk_enable = 2'b11;
        chk_data   = {32'd7, 32'd3};
        chk_expect = {32'd5, 32'd3};
        do_run("stall", -1);

        // The PC never halts: timeout with matching probes.
        gen(3);
        chk_data   = {32'd5, 32'd6};
        chk_expect = {32'd5, 32'd6};
        do_run("timeout", -1);

        // Halt lands exactly on cycle MAX_CYC; start pulsed mid-run is ignored.
        seq.delete();
        for (int i = 0; i < MAX_CYC; i++) seq.push_back(32'h100 + 32'(4 * i));
        halt_pc = seq[MAX_CYC-1];
        do_run("edge", 500);

        // A ten-instruction run exercises the trace window.
        seq.delete();
        for (int i = 0; i < MAX_CYC; i++) seq.push_back(32'h400 + 32'(4 * i));
        halt_pc    = seq[9];
        chk_enable = 2'b00;
        chk_data   = {32'd1, 32'd2};
        do_run("trace10", -1);

        // Randomized runs across all PC patterns and probe combinations.
        for (int r = 0; r < 12; r++) begin
            gen(r % 4);
            chk_enable = 2'($urandom_range(0, 3));
            chk_expect = {32'($urandom), 32'($urandom)};
            chk_data   = chk_expect;
            if ($urandom_range(0, 1) == 1) chk_data[31:0]  = chk_data[31:0]  ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) chk_data[63:32] = chk_data[63:32] ^ (32'd1 << $urandom_range(0, 31));
            do_run($sformatf("rnd%0d", r), (r % 3 == 0) ? 3 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
